as_ip_bind_table: RTL
=====================

AS_IP_BIND_TABLE -- requirements
Module: as_ip_bind_table

Interface
REQ-001 Parameters SHALL be:
- NUM_OUTPUT_QUEUES, default 8, width of the port bitmaps.
- LUT_DEPTH_BITS, default 4, log2 of the entry count.
- LUT_DEPTH, default 2**LUT_DEPTH_BITS, entry count.
- NUM_IQ_BITS, default 3, width of the source port number.
- AGE_BITS, default 4, width of the per-entry age counter.
- DEFAULT_MISS_OUTPUT_PORTS, default 8'h55, flood bitmap used on a miss.

REQ-002 Ports SHALL be:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- src_mac  in  48  packet source MAC.
- src_ip  in  32  packet source IP.
- src_port  in  NUM_IQ_BITS  ingress port number.
- lookup_req  in  1  level request.
- lookup_ack  out  1  result valid.
- dst_ports  out  NUM_OUTPUT_QUEUES  forwarding bitmap.
- drop  out  1  spoofed packet; discard it.
- enforce_en  in  1  1 = a MAC/IP mismatch is a spoof; 0 = relearn the IP.
- age_tick  in  1  aging strobe.
- rd_addr  in  LUT_DEPTH_BITS  direct-read entry index.
- rd_req  in  1  direct-read request.
- rd_ack  out  1  direct-read done.
- rd_valid, rd_protect  out  1 each  entry flags.
- rd_mac  out  48  entry MAC.
- rd_ip  out  32  entry IP.
- rd_oq  out  NUM_OUTPUT_QUEUES  entry port bitmap.
- wr_addr  in  LUT_DEPTH_BITS  direct-write entry index.
- wr_req  in  1  direct-write request.
- wr_ack  out  1  direct-write done.
- wr_valid, wr_protect  in  1 each  flags to write.
- wr_mac  in  48  MAC to write.
- wr_ip  in  32  IP to write.
- wr_oq  in  NUM_OUTPUT_QUEUES  port bitmap to write.
- lut_hit, lut_miss, lut_spoof, learn_fail  out  1 each  single-cycle statistics pulses.

Function
REQ-003 Each entry SHALL hold: valid, protect, mac[47:0], ip[31:0], oq[NUM_OUTPUT_QUEUES-1:0], age[AGE_BITS-1:0]. Entries are register-based, with parallel compare across all entries.

REQ-004 The state machine SHALL use states IDLE, COMPARE and RESOLVE.
- IDLE -> COMPARE when lookup_req=1 and lookup_ack=0.
- COMPARE -> RESOLVE always.
- RESOLVE -> IDLE always.

REQ-005 On the IDLE->COMPARE transition the block SHALL latch src_mac, src_ip, enforce_en and the one-hot decode of src_port (src_port_dec). Inputs need not be held afterwards.

REQ-006 In COMPARE the block SHALL register a match vector: valid & (mac == latched src_mac). The lowest matching index wins. It SHALL also register the lowest index with valid=0 as the free slot.

REQ-007 Latency: lookup_ack, dst_ports, drop and the statistics pulses SHALL become valid 3 cycles after the cycle in which lookup_req is sampled in IDLE.

REQ-008 lookup_ack SHALL stay high until lookup_req is sampled low, then clear the next cycle. dst_ports and drop SHALL hold their values while lookup_ack=1.

REQ-009 RESOLVE outcomes:
- Hit with ip equal: dst_ports = oq & ~src_port_dec; drop=0; lut_hit pulse; entry age reset to 0.
- Hit with ip differing and (enforce_en=1 or protect=1): dst_ports=0; drop=1; lut_spoof pulse; entry unchanged.
- Hit with ip differing, enforce_en=0 and protect=0: entry ip and oq rewritten to the latched values; age=0; forward as a hit; lut_hit pulse.
- Miss: dst_ports = DEFAULT_MISS_OUTPUT_PORTS & ~src_port_dec; drop=0; lut_miss pulse.
  - If a free slot exists, write {valid=1, protect=0, mac, ip, oq=src_port_dec, age=0} there.
  - Otherwise pulse learn_fail; the table is unchanged.
- Hit always has priority over a free slot. A MAC is never duplicated by learning.

REQ-010 Every oq update on a hit SHALL be skipped when protect=1.

REQ-011 Aging: each age_tick SHALL increment the age of every entry with valid=1 and protect=0.
- An entry whose age equals 2**AGE_BITS-1 when a tick arrives SHALL be invalidated instead; the counter never wraps.
- age_tick is honoured in every state.
- A same-cycle refresh of an entry by RESOLVE beats the tick for that entry.

REQ-012 Direct access SHALL be serviced only in IDLE and only when no lookup is being accepted that cycle. Lookup has priority; a held request is served later.
- A write takes effect at the next edge, with age=0; wr_ack pulses 1 cycle after acceptance.
- A read returns the entry 1 cycle after acceptance, together with a rd_ack pulse. rd_* data holds until the next read.
- A read and a write to the same address in the same cycle SHALL return the old data.

REQ-013 A direct write that sets a MAC equal to another valid entry's MAC is permitted. The lowest index wins on lookup.

Reset
REQ-014 While reset=1 the block SHALL:
- clear every valid, protect and age bit;
- drive lookup_ack, rd_ack, wr_ack, drop, lut_hit, lut_miss, lut_spoof and learn_fail to 0, and dst_ports to 0;
- clear all rd_* outputs and latched fields;
- force the state to IDLE, aborting any lookup in progress without a write or an ack.

REQ-015 A lookup_req held across reset deassertion SHALL be accepted on the first cycle after reset. Any table write from the aborted lookup SHALL NOT occur.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
- Empty table; lookup mac=0x001122334455, ip=10.0.0.1, port 2 -> after 3 cycles lookup_ack=1, dst_ports=8'h51, lut_miss pulse; entry 0 learned with oq=8'h04.
- Repeat the same lookup from port 0 -> lut_hit pulse, dst_ports=8'h04, drop=0.
- Same MAC, ip=10.0.0.9, enforce_en=1 -> drop=1, dst_ports=0, lut_spoof pulse; read of entry 0 returns ip=10.0.0.1. With enforce_en=0 -> entry 0 ip becomes 10.0.0.9, lut_hit pulse.
- Fill all 16 entries through wr_req; lookup a new MAC -> lut_miss and learn_fail pulses; the table is unchanged.
- Learned entry plus 16 age_tick pulses with AGE_BITS=4 -> valid=0 on read. A protected entry survives 100 ticks.
- Assert reset in COMPARE -> no ack and no write. Fresh lookup after reset -> miss at the expected latency.

Source files
------------

// File: rtl/as_ip_bind_table.sv
// MAC/IP binding table: register-based LUT with parallel MAC compare,
// spoof detection, source learning, per-entry aging and direct table access.
module as_ip_bind_table #(
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int LUT_DEPTH_BITS = 4,
    parameter int LUT_DEPTH = 2**LUT_DEPTH_BITS,
    parameter int NUM_IQ_BITS = 3,
    parameter int AGE_BITS = 4,
    parameter logic [NUM_OUTPUT_QUEUES-1:0] DEFAULT_MISS_OUTPUT_PORTS = 8'h55
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [47:0]                  src_mac,
    input  logic [31:0]                  src_ip,
    input  logic [NUM_IQ_BITS-1:0]       src_port,
    input  logic                         lookup_req,
    output logic                         lookup_ack,
    output logic [NUM_OUTPUT_QUEUES-1:0] dst_ports,
    output logic                         drop,
    input  logic                         enforce_en,
    input  logic                         age_tick,
    input  logic [LUT_DEPTH_BITS-1:0]    rd_addr,
    input  logic                         rd_req,
    output logic                         rd_ack,
    output logic                         rd_valid,
    output logic                         rd_protect,
    output logic [47:0]                  rd_mac,
    output logic [31:0]                  rd_ip,
    output logic [NUM_OUTPUT_QUEUES-1:0] rd_oq,
    input  logic [LUT_DEPTH_BITS-1:0]    wr_addr,
    input  logic                         wr_req,
    output logic                         wr_ack,
    input  logic                         wr_valid,
    input  logic                         wr_protect,
    input  logic [47:0]                  wr_mac,
    input  logic [31:0]                  wr_ip,
    input  logic [NUM_OUTPUT_QUEUES-1:0] wr_oq,
    output logic                         lut_hit,
    output logic                         lut_miss,
    output logic                         lut_spoof,
    output logic                         learn_fail
);

    typedef enum logic [1:0] {IDLE, COMPARE, RESOLVE} state_t;

    state_t state_q, state_d;

    // Table storage: flags/age are reset, payload fields are not
    logic [LUT_DEPTH-1:0]         valid_q, protect_q;
    logic [47:0]                  mac_q [LUT_DEPTH];
    logic [31:0]                  ip_q  [LUT_DEPTH];
    logic [NUM_OUTPUT_QUEUES-1:0] oq_q  [LUT_DEPTH];
    logic [AGE_BITS-1:0]          age_q [LUT_DEPTH];

    // Request fields captured when a lookup is accepted
    logic [47:0]                  lk_mac_q;
    logic [31:0]                  lk_ip_q;
    logic                         lk_enf_q;
    logic [NUM_OUTPUT_QUEUES-1:0] lk_dec_q, src_port_dec;

    // Compare results carried into RESOLVE
    logic                         hit_q, hit_d, free_q, free_d;
    logic [LUT_DEPTH_BITS-1:0]    hit_idx_q, hit_idx_d, free_idx_q, free_idx_d;

    // Lookup result and statistics registers
    logic                         ack_q, ack_d, drop_q, drop_d;
    logic [NUM_OUTPUT_QUEUES-1:0] dst_q, dst_d;
    logic                         hit_pl_q, hit_pl_d, miss_pl_q, miss_pl_d;
    logic                         spoof_pl_q, spoof_pl_d, lfail_pl_q, lfail_pl_d;

    // Direct access
    logic                         rd_ack_q, wr_ack_q, rd_valid_q, rd_protect_q;
    logic [47:0]                  rd_mac_q;
    logic [31:0]                  rd_ip_q;
    logic [NUM_OUTPUT_QUEUES-1:0] rd_oq_q;

    logic lk_accept, dir_ok, rd_accept, wr_accept;
    logic ip_eq, spoof, relearn, learn;

    assign lk_accept = (state_q == IDLE) && lookup_req && !ack_q;
    assign dir_ok    = (state_q == IDLE) && !lk_accept;
    assign rd_accept = dir_ok && rd_req;
    assign wr_accept = dir_ok && wr_req;

    // RESOLVE decisions; only meaningful while state_q == RESOLVE
    assign ip_eq   = hit_q && (ip_q[hit_idx_q] == lk_ip_q);
    assign spoof   = hit_q && !ip_eq && (lk_enf_q || protect_q[hit_idx_q]);
    assign relearn = hit_q && !ip_eq && !spoof;
    assign learn   = !hit_q && free_q;

    // One-hot decode of the ingress port
    always_comb begin
        src_port_dec = '0;
        for (int i = 0; i < NUM_OUTPUT_QUEUES; i++)
            src_port_dec[i] = (src_port == NUM_IQ_BITS'(i));
    end

    // Parallel MAC compare; descending scan so the lowest index wins
    always_comb begin
        hit_d      = 1'b0;
        hit_idx_d  = '0;
        free_d     = 1'b0;
        free_idx_d = '0;
        for (int i = LUT_DEPTH - 1; i >= 0; i--) begin
            if (valid_q[i] && (mac_q[i] == lk_mac_q)) begin
                hit_d     = 1'b1;
                hit_idx_d = LUT_DEPTH_BITS'(i);
            end
            if (!valid_q[i]) begin
                free_d     = 1'b1;
                free_idx_d = LUT_DEPTH_BITS'(i);
            end
        end
    end

    // Next state plus next lookup outputs and statistics pulses
    always_comb begin
        state_d    = state_q;
        ack_d      = ack_q;
        dst_d      = dst_q;
        drop_d     = drop_q;
        hit_pl_d   = 1'b0;
        miss_pl_d  = 1'b0;
        spoof_pl_d = 1'b0;
        lfail_pl_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (lk_accept) state_d = COMPARE;
                if (ack_q && !lookup_req) ack_d = 1'b0;
            end
            COMPARE: state_d = RESOLVE;
            RESOLVE: begin
                state_d = IDLE;
                ack_d   = 1'b1;
                if (spoof) begin
                    dst_d      = '0;
                    drop_d     = 1'b1;
                    spoof_pl_d = 1'b1;
                end else if (hit_q) begin
                    dst_d    = oq_q[hit_idx_q] & ~lk_dec_q;
                    drop_d   = 1'b0;
                    hit_pl_d = 1'b1;
                end else begin
                    dst_d      = DEFAULT_MISS_OUTPUT_PORTS & ~lk_dec_q;
                    drop_d     = 1'b0;
                    miss_pl_d  = 1'b1;
                    lfail_pl_d = !free_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control, capture and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            dst_q      <= '0;
            drop_q     <= 1'b0;
            hit_pl_q   <= 1'b0;
            miss_pl_q  <= 1'b0;
            spoof_pl_q <= 1'b0;
            lfail_pl_q <= 1'b0;
            lk_mac_q   <= '0;
            lk_ip_q    <= '0;
            lk_enf_q   <= 1'b0;
            lk_dec_q   <= '0;
            hit_q      <= 1'b0;
            hit_idx_q  <= '0;
            free_q     <= 1'b0;
            free_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            dst_q      <= dst_d;
            drop_q     <= drop_d;
            hit_pl_q   <= hit_pl_d;
            miss_pl_q  <= miss_pl_d;
            spoof_pl_q <= spoof_pl_d;
            lfail_pl_q <= lfail_pl_d;
            if (lk_accept) begin
                lk_mac_q <= src_mac;
                lk_ip_q  <= src_ip;
                lk_enf_q <= enforce_en;
                lk_dec_q <= src_port_dec;
            end
            if (state_q == COMPARE) begin
                hit_q      <= hit_d;
                hit_idx_q  <= hit_idx_d;
                free_q     <= free_d;
                free_idx_q <= free_idx_d;
            end
        end
    end

    // Table update: aging first, later writes (direct, refresh, learn) override it
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            protect_q <= '0;
            for (int i = 0; i < LUT_DEPTH; i++) age_q[i] <= '0;
        end else begin
            if (age_tick) begin
                for (int i = 0; i < LUT_DEPTH; i++) begin
                    if (valid_q[i] && !protect_q[i]) begin
                        if (age_q[i] == {AGE_BITS{1'b1}}) valid_q[i] <= 1'b0;
                        else                              age_q[i]   <= age_q[i] + 1'b1;
                    end
                end
            end
            if (wr_accept) begin
                valid_q[wr_addr]   <= wr_valid;
                protect_q[wr_addr] <= wr_protect;
                mac_q[wr_addr]     <= wr_mac;
                ip_q[wr_addr]      <= wr_ip;
                oq_q[wr_addr]      <= wr_oq;
                age_q[wr_addr]     <= '0;
            end
            if (state_q == RESOLVE) begin
                if (ip_eq || relearn) begin
                    valid_q[hit_idx_q] <= valid_q[hit_idx_q];
                    age_q[hit_idx_q]   <= '0;
                end
                if (relearn) begin
                    ip_q[hit_idx_q] <= lk_ip_q;
                    oq_q[hit_idx_q] <= lk_dec_q;
                end
                if (learn) begin
                    valid_q[free_idx_q]   <= 1'b1;
                    protect_q[free_idx_q] <= 1'b0;
                    mac_q[free_idx_q]     <= lk_mac_q;
                    ip_q[free_idx_q]      <= lk_ip_q;
                    oq_q[free_idx_q]      <= lk_dec_q;
                    age_q[free_idx_q]     <= '0;
                end
            end
        end
    end

    // Direct read/write acknowledge and read data (pre-write contents)
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ack_q     <= 1'b0;
            wr_ack_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_protect_q <= 1'b0;
            rd_mac_q     <= '0;
            rd_ip_q      <= '0;
            rd_oq_q      <= '0;
        end else begin
            rd_ack_q <= rd_accept;
            wr_ack_q <= wr_accept;
            if (rd_accept) begin
                rd_valid_q   <= valid_q[rd_addr];
                rd_protect_q <= protect_q[rd_addr];
                rd_mac_q     <= mac_q[rd_addr];
                rd_ip_q      <= ip_q[rd_addr];
                rd_oq_q      <= oq_q[rd_addr];
            end
        end
    end

    assign lookup_ack = ack_q;
    assign dst_ports  = dst_q;
    assign drop       = drop_q;
    assign lut_hit    = hit_pl_q;
    assign lut_miss   = miss_pl_q;
    assign lut_spoof  = spoof_pl_q;
    assign learn_fail = lfail_pl_q;
    assign rd_ack     = rd_ack_q;
    assign wr_ack     = wr_ack_q;
    assign rd_valid   = rd_valid_q;
    assign rd_protect = rd_protect_q;
    assign rd_mac     = rd_mac_q;
    assign rd_ip      = rd_ip_q;
    assign rd_oq      = rd_oq_q;

endmodule
